// File: rtl/cam_fb_writer.sv
// Camera pixel stream to framebuffer writer: RGB565 -> RGB444, optional 2x2 decimation,
// linear write addressing and whole-frame bank swapping between a write bank and a display bank.
module cam_fb_writer #(
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int DECIM      = 1,
    parameter int ADDR_W     = 17,
    parameter int DOUBLE_BUF = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       pixel_data,
    input  logic              pixel_valid,
    input  logic              frame_done,
    input  logic              enable,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [11:0]       wr_data,
    output logic              wr_bank,
    output logic              disp_bank,
    output logic              frame_strobe,
    output logic [7:0]        frame_count,
    output logic              short_frame,
    output logic              overrun,
    output logic              fsm_state
);

    localparam int XW         = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int YW         = $clog2(V_ACTIVE + 1);
    localparam int CW         = ADDR_W + 1;
    localparam int EXPECT_INT = (H_ACTIVE >> DECIM) * (V_ACTIVE >> DECIM);

    localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0] Y_END  = YW'(V_ACTIVE);
    localparam logic [CW-1:0] EXPECT = CW'(EXPECT_INT);

    typedef enum logic {
        SYNC   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [CW-1:0] count;
    logic [CW-1:0] count_after;
    logic          pix;
    logic          in_frame;
    logic          keep;
    logic          room;
    logic          do_write;
    logic          do_over;
    logic          open_frame;
    logic          close_frame;
    logic          commit;

    // A pixel coinciding with frame_done is counted before the commit decision.
    always_comb begin
        pix         = (state == ACTIVE) && pixel_valid;
        in_frame    = (y != Y_END);
        keep        = (DECIM == 0) || (!x[0] && !y[0]);
        room        = (count != EXPECT);
        do_write    = pix && in_frame && keep && room;
        do_over     = pix && (!in_frame || (keep && !room));
        count_after = do_write ? count + CW'(1) : count;
        open_frame  = (state == SYNC) && frame_done && enable;
        close_frame = (state == ACTIVE) && frame_done;
        commit      = close_frame && (count_after == EXPECT);
    end

    always_comb begin
        state_next = state;
        case (state)
            SYNC:    if (frame_done && enable) state_next = ACTIVE;
            ACTIVE:  if (frame_done && !enable) state_next = SYNC;
            default: state_next = SYNC;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= SYNC;
        end else begin
            state <= state_next;
        end
    end

    assign fsm_state = (state == ACTIVE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x            <= '0;
            y            <= '0;
            count        <= '0;
            wr_en        <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= '0;
            wr_bank      <= 1'b0;
            disp_bank    <= 1'b0;
            frame_strobe <= 1'b0;
            frame_count  <= '0;
            short_frame  <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            wr_en        <= do_write;
            frame_strobe <= commit;
            if (do_write) begin
                wr_addr <= count[ADDR_W-1:0];
                wr_data <= {pixel_data[15:12], pixel_data[10:7], pixel_data[4:1]};
            end
            if (do_over) overrun <= 1'b1;
            if (close_frame && !commit) short_frame <= 1'b1;
            if (commit) begin
                frame_count <= frame_count + 8'd1;
                if (DOUBLE_BUF != 0) begin
                    disp_bank <= wr_bank;
                    wr_bank   <= ~wr_bank;
                end
            end
            // Position restarts at every frame boundary; y parks at V_ACTIVE to flag late rows.
            if (open_frame || close_frame) begin
                x     <= '0;
                y     <= '0;
                count <= '0;
            end else if (pix) begin
                count <= count_after;
                if (x == X_LAST) begin
                    x <= '0;
                    if (in_frame) y <= y + YW'(1);
                end else begin
                    x <= x + XW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_cam_fb_writer.sv
// Directed bench for cam_fb_writer: two instances (full-rate and 2x2 decimated) on a shrunken
// 8x6 frame share one stimulus stream; writes are scored against expected {addr,data} queues.
module tb_cam_fb_writer;

    localparam int H = 8;
    localparam int V = 6;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] pixel_data = '0;
    logic        pixel_valid = 1'b0;
    logic        frame_done = 1'b0;
    logic        enable = 1'b0;

    logic        wr_en_a, wr_bank_a, disp_bank_a, frame_strobe_a, short_frame_a, overrun_a, fsm_state_a;
    logic [5:0]  wr_addr_a;
    logic [11:0] wr_data_a;
    logic [7:0]  frame_count_a;
    logic        wr_en_b, wr_bank_b, disp_bank_b, frame_strobe_b, short_frame_b, overrun_b, fsm_state_b;
    logic [3:0]  wr_addr_b;
    logic [11:0] wr_data_b;
    logic [7:0]  frame_count_b;

    cam_fb_writer #(.H_ACTIVE(H), .V_ACTIVE(V), .DECIM(0), .ADDR_W(6), .DOUBLE_BUF(1)) dut_a (
        .clk(clk), .rst(rst), .pixel_data(pixel_data), .pixel_valid(pixel_valid),
        .frame_done(frame_done), .enable(enable), .wr_en(wr_en_a), .wr_addr(wr_addr_a),
        .wr_data(wr_data_a), .wr_bank(wr_bank_a), .disp_bank(disp_bank_a),
        .frame_strobe(frame_strobe_a), .frame_count(frame_count_a), .short_frame(short_frame_a),
        .overrun(overrun_a), .fsm_state(fsm_state_a)
    );

    cam_fb_writer #(.H_ACTIVE(H), .V_ACTIVE(V), .DECIM(1), .ADDR_W(4), .DOUBLE_BUF(1)) dut_b (
        .clk(clk), .rst(rst), .pixel_data(pixel_data), .pixel_valid(pixel_valid),
        .frame_done(frame_done), .enable(enable), .wr_en(wr_en_b), .wr_addr(wr_addr_b),
        .wr_data(wr_data_b), .wr_bank(wr_bank_b), .disp_bank(disp_bank_b),
        .frame_strobe(frame_strobe_b), .frame_count(frame_count_b), .short_frame(short_frame_b),
        .overrun(overrun_b), .fsm_state(fsm_state_b)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation still running at %0t", $time);
        $fatal(1, "timeout");
    end

    // scoreboard
    logic [17:0] exp_qa[$];
    logic [15:0] exp_qb[$];
    logic [17:0] ea;
    logic [15:0] eb;
    int          ia = 0, ib = 0;
    int          a_writes = 0, b_writes = 0, a_err = 0, b_err = 0, a_strobes = 0, b_strobes = 0;
    logic [5:0]  a_last_addr = '0;
    logic [3:0]  b_last_addr = '0;
    logic [11:0] a_last_data = '0, b_last_data = '0;
    int          n_checks = 0, n_fail = 0;

    always @(negedge clk) begin
        if (wr_en_a) begin
            a_writes++;
            a_last_addr = wr_addr_a;
            a_last_data = wr_data_a;
            if (exp_qa.size() == 0) a_err++;
            else begin
                ea = exp_qa.pop_front();
                if (ea !== {wr_addr_a, wr_data_a}) a_err++;
            end
        end
        if (wr_en_b) begin
            b_writes++;
            b_last_addr = wr_addr_b;
            b_last_data = wr_data_b;
            if (exp_qb.size() == 0) b_err++;
            else begin
                eb = exp_qb.pop_front();
                if (eb !== {wr_addr_b, wr_data_b}) b_err++;
            end
        end
        if (frame_strobe_a) a_strobes++;
        if (frame_strobe_b) b_strobes++;
    end

    function automatic logic [11:0] to444(input logic [15:0] d);
        return {d[15:12], d[10:7], d[4:1]};
    endfunction

    // driver tasks
    task automatic cycle(input logic pv, input logic [15:0] pd, input logic fd);
        pixel_valid = pv;
        pixel_data  = pd;
        frame_done  = fd;
        @(posedge clk);
        #1;
        pixel_valid = 1'b0;
        frame_done  = 1'b0;
    endtask

    task automatic close_frame();
        cycle(1'b0, 16'h0000, 1'b1);
        ia = 0;
        ib = 0;
    endtask

    // rows of H pixels; mode 0 = varied pattern, 1 = pure red. exp_on: the DUT should be capturing.
    task automatic send_frame(input int rows, input bit fd_last, input bit exp_on, input int mode);
        logic [15:0] d;
        for (int r = 0; r < rows; r++) begin
            for (int c = 0; c < H; c++) begin
                d = (mode == 1) ? 16'hF800 : 16'(32'hA5C3 ^ (r * 32'h0913) ^ (c * 32'h2101));
                if (exp_on && r < V) begin
                    exp_qa.push_back({6'(ia), to444(d)});
                    ia++;
                    if ((r % 2 == 0) && (c % 2 == 0)) begin
                        exp_qb.push_back({4'(ib), to444(d)});
                        ib++;
                    end
                end
                cycle(1'b1, d, fd_last && (r == rows - 1) && (c == H - 1));
            end
        end
        if (fd_last) begin
            ia = 0;
            ib = 0;
        end
    endtask

    // tests
    task automatic test_reset();
        n_checks++;
        if ({wr_en_a, wr_addr_a, wr_data_a, wr_bank_a, disp_bank_a, frame_strobe_a, frame_count_a,
             short_frame_a, overrun_a, fsm_state_a} !== '0) begin
            n_fail++;
            $display("FAIL reset_a: outputs not all zero (wr_en=%0b addr=%0d cnt=%0d fsm=%0b)",
                     wr_en_a, wr_addr_a, frame_count_a, fsm_state_a);
        end
        n_checks++;
        if ({wr_en_b, wr_addr_b, wr_data_b, wr_bank_b, disp_bank_b, frame_strobe_b, frame_count_b,
             short_frame_b, overrun_b, fsm_state_b} !== '0) begin
            n_fail++;
            $display("FAIL reset_b: outputs not all zero (wr_en=%0b addr=%0d cnt=%0d fsm=%0b)",
                     wr_en_b, wr_addr_b, frame_count_b, fsm_state_b);
        end
    endtask

    task automatic test_idle_pixels();
        int wa, wb;
        wa = a_writes;
        wb = b_writes;
        enable = 1'b1;
        send_frame(1, 1'b0, 1'b0, 0);
        enable = 1'b0;
        close_frame();
        send_frame(1, 1'b0, 1'b0, 0);
        cycle(1'b0, 16'h0, 1'b0);
        n_checks++;
        if ((a_writes - wa) !== 0 || (b_writes - wb) !== 0) begin
            n_fail++;
            $display("FAIL idle_writes: got a=%0d b=%0d writes, expected 0", a_writes - wa, b_writes - wb);
        end
        n_checks++;
        if ({fsm_state_a, fsm_state_b} !== 2'b00) begin
            n_fail++;
            $display("FAIL idle_state: got %b, expected 00", {fsm_state_a, fsm_state_b});
        end
    endtask

    task automatic test_full_frame();
        int wa, wb;
        enable = 1'b1;
        close_frame();
        n_checks++;
        if ({fsm_state_a, fsm_state_b} !== 2'b11) begin
            n_fail++;
            $display("FAIL full_open: state got %b, expected 11", {fsm_state_a, fsm_state_b});
        end
        wa = a_writes;
        wb = b_writes;
        send_frame(V, 1'b0, 1'b1, 0);
        close_frame();
        n_checks++;
        if ({frame_strobe_a, frame_strobe_b} !== 2'b11) begin
            n_fail++;
            $display("FAIL full_strobe: got %b, expected 11", {frame_strobe_a, frame_strobe_b});
        end
        n_checks++;
        if ({wr_bank_a, disp_bank_a, frame_count_a, wr_bank_b, disp_bank_b, frame_count_b} !==
            {1'b1, 1'b0, 8'd1, 1'b1, 1'b0, 8'd1}) begin
            n_fail++;
            $display("FAIL full_banks: got a=%b/%b/%0d b=%b/%b/%0d, expected 1/0/1 each",
                     wr_bank_a, disp_bank_a, frame_count_a, wr_bank_b, disp_bank_b, frame_count_b);
        end
        cycle(1'b0, 16'h0, 1'b0);
        n_checks++;
        if ({frame_strobe_a, frame_strobe_b} !== 2'b00 || a_strobes !== 1 || b_strobes !== 1) begin
            n_fail++;
            $display("FAIL full_strobe_once: strobes a=%0d b=%0d, expected 1 each", a_strobes, b_strobes);
        end
        n_checks++;
        if ((a_writes - wa) !== 48 || (b_writes - wb) !== 12) begin
            n_fail++;
            $display("FAIL full_writes: got a=%0d b=%0d, expected 48 12", a_writes - wa, b_writes - wb);
        end
        n_checks++;
        if (a_err !== 0 || b_err !== 0 || exp_qa.size() !== 0 || exp_qb.size() !== 0) begin
            n_fail++;
            $display("FAIL full_data: errors a=%0d b=%0d left a=%0d b=%0d, expected all 0",
                     a_err, b_err, exp_qa.size(), exp_qb.size());
        end
        n_checks++;
        if (a_last_addr !== 6'd47 || b_last_addr !== 4'd11) begin
            n_fail++;
            $display("FAIL full_last_addr: got a=%0d b=%0d, expected 47 11", a_last_addr, b_last_addr);
        end
    endtask

    task automatic test_decim_red();
        int wb;
        wb = b_writes;
        send_frame(V, 1'b0, 1'b1, 1);
        close_frame();
        cycle(1'b0, 16'h0, 1'b0);
        n_checks++;
        if ((b_writes - wb) !== 12 || b_last_addr !== 4'd11 || b_last_data !== 12'hF00) begin
            n_fail++;
            $display("FAIL decim_red: got %0d writes last=%0d data=%h, expected 12 11 f00",
                     b_writes - wb, b_last_addr, b_last_data);
        end
        n_checks++;
        if ({wr_bank_b, disp_bank_b, frame_count_b, a_last_data} !== {1'b0, 1'b1, 8'd2, 12'hF00}) begin
            n_fail++;
            $display("FAIL decim_commit: got b=%b/%b/%0d a_data=%h, expected 0/1/2 f00",
                     wr_bank_b, disp_bank_b, frame_count_b, a_last_data);
        end
    endtask

    task automatic test_short_frame();
        int wa;
        wa = a_writes;
        send_frame(2, 1'b0, 1'b1, 0);
        close_frame();
        n_checks++;
        if ({short_frame_a, short_frame_b, frame_strobe_a, frame_strobe_b} !== 4'b1100) begin
            n_fail++;
            $display("FAIL short_flag: got short=%b%b strobe=%b%b, expected 11 00",
                     short_frame_a, short_frame_b, frame_strobe_a, frame_strobe_b);
        end
        n_checks++;
        if ({wr_bank_a, disp_bank_a, frame_count_a, wr_bank_b, frame_count_b} !==
            {1'b0, 1'b1, 8'd2, 1'b0, 8'd2} || (a_writes - wa) !== 16) begin
            n_fail++;
            $display("FAIL short_noswap: got wr_bank=%b cnt=%0d writes=%0d, expected 0 2 16",
                     wr_bank_a, frame_count_a, a_writes - wa);
        end
        // enable dropped mid-frame only matters at the boundary
        enable = 1'b0;
        send_frame(V, 1'b0, 1'b1, 0);
        enable = 1'b1;
        close_frame();
        n_checks++;
        if ({wr_bank_a, disp_bank_a, frame_count_a, fsm_state_a, frame_count_b} !==
            {1'b1, 1'b0, 8'd3, 1'b1, 8'd3}) begin
            n_fail++;
            $display("FAIL short_recover: got %b/%b/%0d fsm=%b b_cnt=%0d, expected 1/0/3 1 3",
                     wr_bank_a, disp_bank_a, frame_count_a, fsm_state_a, frame_count_b);
        end
    endtask

    task automatic test_overrun();
        int wa, wb;
        n_checks++;
        if ({overrun_a, overrun_b} !== 2'b00) begin
            n_fail++;
            $display("FAIL overrun_pre: got %b, expected 00", {overrun_a, overrun_b});
        end
        wa = a_writes;
        wb = b_writes;
        send_frame(V + 1, 1'b0, 1'b1, 0);
        close_frame();
        cycle(1'b0, 16'h0, 1'b0);
        n_checks++;
        if ({overrun_a, overrun_b} !== 2'b11 || (a_writes - wa) !== 48 || (b_writes - wb) !== 12) begin
            n_fail++;
            $display("FAIL overrun_flag: got ovr=%b writes a=%0d b=%0d, expected 11 48 12",
                     {overrun_a, overrun_b}, a_writes - wa, b_writes - wb);
        end
        n_checks++;
        if ({a_last_addr, b_last_addr, frame_count_a, frame_count_b, wr_bank_a} !==
            {6'd47, 4'd11, 8'd4, 8'd4, 1'b0} || a_err !== 0 || b_err !== 0) begin
            n_fail++;
            $display("FAIL overrun_commit: got last=%0d/%0d cnt=%0d bank=%b err=%0d/%0d, expected 47/11 4 0 0/0",
                     a_last_addr, b_last_addr, frame_count_a, wr_bank_a, a_err, b_err);
        end
    endtask

    task automatic test_back_to_back();
        send_frame(V, 1'b1, 1'b1, 0);
        n_checks++;
        if ({wr_en_a, wr_addr_a, frame_strobe_a, frame_strobe_b} !== {1'b1, 6'd47, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL same_cycle: got wr_en=%b addr=%0d strobe=%b%b, expected 1 47 11",
                     wr_en_a, wr_addr_a, frame_strobe_a, frame_strobe_b);
        end
        cycle(1'b0, 16'h0, 1'b0);
        n_checks++;
        if ({frame_count_a, frame_count_b, wr_bank_a, disp_bank_a} !== {8'd5, 8'd5, 1'b1, 1'b0} ||
            a_err !== 0 || exp_qa.size() !== 0) begin
            n_fail++;
            $display("FAIL same_cycle_commit: got cnt=%0d/%0d bank=%b/%b err=%0d left=%0d, expected 5/5 1/0 0 0",
                     frame_count_a, frame_count_b, wr_bank_a, disp_bank_a, a_err, exp_qa.size());
        end
    endtask

    task automatic test_disable_boundary();
        int wa, wb;
        enable = 1'b0;
        close_frame();
        wa = a_writes;
        wb = b_writes;
        send_frame(V, 1'b0, 1'b0, 0);
        cycle(1'b0, 16'h0, 1'b0);
        n_checks++;
        if ((a_writes - wa) !== 0 || (b_writes - wb) !== 0 || {fsm_state_a, fsm_state_b} !== 2'b00 ||
            frame_count_a !== 8'd5) begin
            n_fail++;
            $display("FAIL disable: got writes=%0d/%0d fsm=%b%b cnt=%0d, expected 0/0 00 5",
                     a_writes - wa, b_writes - wb, fsm_state_a, fsm_state_b, frame_count_a);
        end
    endtask

    task automatic test_reset_mid_frame();
        int wa;
        enable = 1'b1;
        close_frame();
        send_frame(2, 1'b0, 1'b1, 0);
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({wr_en_a, wr_addr_a, wr_data_a, wr_bank_a, disp_bank_a, frame_strobe_a, frame_count_a,
             short_frame_a, overrun_a, fsm_state_a, wr_en_b, frame_count_b, fsm_state_b,
             short_frame_b, overrun_b} !== '0) begin
            n_fail++;
            $display("FAIL mid_reset: got wr_en=%b cnt=%0d short=%b ovr=%b fsm=%b%b, expected all 0",
                     wr_en_a, frame_count_a, short_frame_a, overrun_a, fsm_state_a, fsm_state_b);
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        exp_qa.delete();
        exp_qb.delete();
        ia = 0;
        ib = 0;
        rst = 1'b0;
        wa = a_writes;
        send_frame(1, 1'b0, 1'b0, 0);
        cycle(1'b0, 16'h0, 1'b0);
        n_checks++;
        if ((a_writes - wa) !== 0 || fsm_state_a !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_sync: got writes=%0d fsm=%b, expected 0 0", a_writes - wa, fsm_state_a);
        end
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b0;
        cycle(1'b0, 16'h0, 1'b0);
        test_reset();
        test_idle_pixels();
        test_full_frame();
        test_decim_red();
        test_short_frame();
        test_overrun();
        test_back_to_back();
        test_disable_boundary();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
